// File: rtl/key_debounce_irq.sv
// key_debounce_irq: per-channel key synchroniser, debouncer, edge detector and pending/overrun interrupt latch
module key_debounce_irq #(
  parameter int N_KEYS      = 4,
  parameter int DB_CYCLES   = 50,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [N_KEYS-1:0]   key,
  input  logic [2*N_KEYS-1:0] edge_mode,
  input  logic [N_KEYS-1:0]   irq_clr,
  output logic [N_KEYS-1:0]   key_state,
  output logic [N_KEYS-1:0]   irq_pending,
  output logic [N_KEYS-1:0]   irq_overrun,
  output logic                irq
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   d, pend, ovr, s, hit, ev;
    assign s   = sync[SYNC_STAGES-1];
    assign hit = (s != d) && (cnt == CNT_W'(DB_CYCLES - 1));
    // d still holds the old level here: d=1 means the accepted change is a press
    assign ev  = hit & (d ? edge_mode[2*i] : edge_mode[2*i+1]);
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        sync <= '1;
        cnt  <= '0;
        d    <= 1'b1;
        pend <= 1'b0;
        ovr  <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], key[i]};
        cnt  <= (s == d || hit) ? '0 : cnt + 1'b1;
        d    <= hit ? s : d;
        pend <= ev | (pend & ~irq_clr[i]);
        ovr  <= (ev & pend & ~irq_clr[i]) | (ovr & ~irq_clr[i]);
      end
    assign key_state[i]   = ~d;
    assign irq_pending[i] = pend;
    assign irq_overrun[i] = ovr;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) irq <= 1'b0;
    else irq <= |irq_pending;
endmodule

// File: doc/key_debounce_irq.md
Name: key_debounce_irq

Overview:
- Parametrised N-channel push-button front end for the AHB-Lite Cortex-M0 system. Key pins are active-low and idle high.
- Per channel: synchronises the raw key pin, debounces it, and detects press and release edges according to a per-channel edge mode.
- Each detected edge latches a pending bit. Pending bits are cleared by write-1-to-clear pulses from the AHB register slice.
- Drives one OR-ed interrupt line into the NVIC and replaces the fixed single-key glue logic.

Parameters:
- N_KEYS, 4, number of key channels.
- DB_CYCLES, 50, number of consecutive stable synchronised cycles required to accept a new level; must be ≥ 2.
- CNT_W, 16, debounce counter width; 2^CNT_W must exceed DB_CYCLES.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser; must be ≥ 2.

Ports:
- sys_clk  input  1  system clock; all state is on the rising edge.
- sys_rst_n  input  1  reset, asynchronous, active-low.
- key  input  N_KEYS  raw key pins, asynchronous, 0 = pressed.
- edge_mode  input  2*N_KEYS  per channel i, bits [2i+1:2i]: 00 = off, 01 = press, 10 = release, 11 = both.
- irq_clr  input  N_KEYS  one-cycle write-1-to-clear pulses for the pending and overrun bits.
- key_state  output  N_KEYS  debounced level, 1 = pressed.
- irq_pending  output  N_KEYS  latched edge events.
- irq_overrun  output  N_KEYS  sticky flag: event arrived while the channel was already pending.
- irq  output  1  OR of irq_pending, driven from registers only, no glitches.

Behaviour:
- Interface: one clock, sys_clk; sys_rst_n is asynchronous, active-low.
- Reset values:
  - all synchroniser stages = 1 (idle level);
  - debounced raw level = 1, so key_state = 0;
  - counters = 0;
  - irq_pending = 0, irq_overrun = 0, irq = 0.
- Reset asserted mid-debounce or with a bit pending discards all state immediately. After release, a key still held low is reported through the normal debounce path: a press edge, latency as below.
- Synchroniser: SYNC_STAGES-deep shift register per channel. s = last stage.
- Debounce, per channel, with stable register d:
  - s == d: counter ← 0.
  - s != d and counter < DB_CYCLES-1: counter ← counter+1.
  - s != d and counter == DB_CYCLES-1: d ← s, counter ← 0.
  - Result: a level change seen at s for DB_CYCLES consecutive cycles updates d on the DB_CYCLES-th edge.
  - Any return of s to d before that restarts the count; glitches shorter than DB_CYCLES cycles are invisible.
  - Latency pin → key_state = SYNC_STAGES + DB_CYCLES cycles, ±1 for pin sampling phase.
- key_state = ~d.
- Edge events:
  - press = d transitions 1→0; release = d transitions 0→1.
  - An event is qualified by edge_mode as sampled in the same cycle d updates.
  - Events are computed from the counter-hit condition, so irq_pending sets on the same edge that key_state changes.
- Pending, per channel:
  - qualified event → 1;
  - else irq_clr → 0;
  - event and irq_clr in the same cycle → pending = 1 (set wins).
- Overrun, per channel:
  - set when a qualified event occurs while pending is already 1 and irq_clr is not asserted that cycle;
  - cleared by irq_clr unless it is set in that same cycle.
- edge_mode changes:
  - take effect on the next cycle;
  - switching a channel to 00 does not clear its existing pending or overrun bit;
  - debouncing continues regardless of mode.
- irq = |irq_pending; asserts one cycle after the pending bit is set (it is a register output).
- Channels are fully independent; simultaneous events on several channels all latch in the same cycle.
- Counter never exceeds DB_CYCLES-1, so there is no wrap-around.

Test Plan:
Bench uses a 20 ps clock period and default parameters.
1. Reset, then hold key = 4'b1111 for 2000 cycles → key_state = 0, irq_pending = 0, irq = 0 throughout.
2. edge_mode = 8'h55; key[0] = 0 held → key_state[0] rises 52 ±1 cycles later, irq_pending = 4'b0001 on the same edge, irq = 1 the next cycle; pulse irq_clr = 4'b0001 → irq_pending = 0, irq = 0.
3. Bounce key[1]: pulses of 30 cycles low / 30 cycles high, repeated 10 times, then release high → key_state[1] never changes, irq_pending[1] stays 0.
4. edge_mode[5:4] = 11; press then release key[2], both held 100 cycles, no clear → irq_pending[2] = 1 after the press, irq_overrun[2] = 1 after the release; a single irq_clr[2] clears both.
5. With key[3] about to be accepted as released, assert irq_clr[3] in exactly the event cycle (edge_mode[7:6] = 10) → irq_pending[3] = 1 afterwards, irq_overrun[3] = 0.
6. Hold key[0] low 40 cycles, assert sys_rst_n = 0 for 3 cycles, keep key[0] low → all outputs 0 during reset; after release, key_state[0] = 1 and irq_pending[0] = 1 exactly 52 ±1 cycles later (edge_mode[1:0] = 01).
